scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Upstream stage of the 3-to-8 one-hot select decoder.
- Generates the 3-bit select index that the decoder consumes, stepping through positions 0..7 with a programmable dwell time per position.
- Supports up/down direction, continuous or one-shot sweeps, pause and abort.
- Provides a valid flag so the decoder output can be blanked while the sequencer is idle; the decoder's reset input is driven from !sel_valid.

Parameters:
DWELL_CYCLES, 4, clock cycles each position is held; legal range 1..65535; 1 advances every cycle
CNT_W, $clog2(DWELL_CYCLES)+1, dwell counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; direction and one-shot mode are captured here
stop  input  1  abort; returns to IDLE on the next edge
enable  input  1  when 0 in RUN, dwell counter and position freeze
dir  input  1  0 = up (0→7), 1 = down (7→0); sampled only with start
oneshot  input  1  1 = single sweep then done; 0 = wrap forever; sampled only with start
sel  output  3  current position, to the decoder S input
sel_valid  output  1  1 while sel is a live scan position
tick  output  1  one-cycle pulse in the first cycle sel shows a newly advanced value
done  output  1  one-cycle pulse when a one-shot sweep completes
busy  output  1  1 while state is not IDLE

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time including mid-sweep): state=IDLE, sel=0, sel_valid=0, tick=0, done=0, busy=0, dwell counter=0, latched dir and oneshot=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - sel holds its last value.
  - sel_valid=0.
  - start=1 at an edge → RUN. On that edge: sel = 0 if dir=0, else 7; sel_valid=1; busy=1; counter=0; dir and oneshot latched.
- RUN:
  - When enable=1, the counter increments each cycle.
  - When counter == DWELL_CYCLES-1 and enable=1 (the terminal count): counter clears and the sel update below is applied.
  - Non-final position: sel advances ±1 with modulo-8 wrap (7→0 up, 0→7 down), and tick=1 in the following cycle.
  - Final position, i.e. latched oneshot=1 and sel = 7 (up) or 0 (down): → DONE. sel is held, sel_valid=0, done=1, no tick.
  - enable=0: counter and sel hold, no tick; sel_valid stays 1.
- DONE: lasts exactly one cycle with done=1, busy=1, then → IDLE.
- Timing:
  - Each position is visible on sel for exactly DWELL_CYCLES enabled cycles.
  - A one-shot sweep holds sel_valid for 8×DWELL_CYCLES enabled cycles, then done follows.
- Simultaneous events:
  - stop and start in the same cycle: stop wins → IDLE.
  - start in RUN: the sweep restarts from its start position with the newly sampled dir/oneshot; counter=0; no tick, no done.
  - start in DONE: ignored.
  - stop in RUN or DONE: → IDLE next edge; sel_valid=0, sel held, no done pulse.
  - enable is ignored outside RUN.
- DWELL_CYCLES=1: sel changes every enabled cycle and tick is high continuously while advancing.

Optional Feature:
- Macro: SCAN_SEQUENCER_SKIP_MASK_EN.
- When defined:
  - Adds input skip_mask[7:0]; bit i=1 excludes position i.
  - Start position is the first unmasked position in the sweep direction.
  - Each advance moves to the next unmasked position, with wrap.
  - One-shot completes when no unmasked position remains before the wrap point.
  - start while skip_mask=8'hFF is ignored.
  - skip_mask=8'hFF sampled at a terminal count in RUN → IDLE, no done.
  - skip_mask is sampled only at start and at terminal counts.
- When undefined: no port is added, and all 8 positions are always visited.

Test Plan:
- Reset mid-sweep, sel=5 → all outputs zero immediately (asynchronous); after release, state is IDLE with sel=0.
- DWELL_CYCLES=2, dir=0, oneshot=1, one start pulse:
  - sel reads 0,0,1,1,...,7,7 over 16 cycles with sel_valid=1.
  - tick appears 7 times.
  - done=1 for 1 cycle, then busy=0, sel=7.
- DWELL_CYCLES=1, dir=1, oneshot=0 → sel reads 7,6,...,0,7,6; the wrap 0→7 produces a tick; done never asserts.
- Pause: enable=0 for 5 cycles at sel=3 → sel holds 3, no tick; enable=1 resumes and sel=3 for the remaining dwell only.
- Simultaneous start+stop in RUN → IDLE, sel_valid=0, no done; a separate start while sel=4 restarts at sel=0 with the counter cleared.
- With SCAN_SEQUENCER_SKIP_MASK_EN, skip_mask=8'b1010_1010, dir=0, oneshot=1, DWELL_CYCLES=1 → sel reads 0,2,4,6, then done; skip_mask=8'hFF with start → busy stays 0.

Source files
------------

// File: rtl/scan_sequencer.sv
// Select-index sequencer feeding the 3-to-8 decoder: steps sel through 0..7 with a programmable dwell.
// Optional position skipping is enabled by defining SCAN_SEQUENCER_SKIP_MASK_EN.
module scan_sequencer #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       enable,
  input  logic       dir,
  input  logic       oneshot,
`ifdef SCAN_SEQUENCER_SKIP_MASK_EN
  input  logic [7:0] skip_mask,
`endif
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       tick,
  output logic       done,
  output logic       busy
);

  localparam int CNT_W = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             oneshot_q, oneshot_d;
  logic [7:0]       mask;
  logic             start_ok;

`ifdef SCAN_SEQUENCER_SKIP_MASK_EN
  assign mask = skip_mask;
`else
  assign mask = 8'h00;
`endif

  // A fully masked ring has no live position, so start is refused.
  assign start_ok = start && (mask != 8'hFF);

  // First unmasked position in the sweep direction.
  function automatic logic [2:0] first_pos(input logic [7:0] m, input logic d);
    logic [2:0] p;
    first_pos = d ? 3'd7 : 3'd0;
    for (int i = 0; i < 8; i++) begin
      p = d ? 3'(i) : 3'(7 - i);
      if (!m[p]) first_pos = p;
    end
  endfunction

  // Nearest unmasked position after cur, wrapping modulo 8.
  function automatic logic [2:0] next_pos(input logic [2:0] cur, input logic [7:0] m,
                                          input logic d);
    logic [2:0] p;
    next_pos = d ? cur - 3'd1 : cur + 3'd1;
    for (int k = 7; k >= 1; k--) begin
      p = d ? cur - 3'(k) : cur + 3'(k);
      if (!m[p]) next_pos = p;
    end
  endfunction

  // True when no unmasked position lies between cur and the wrap point.
  function automatic logic last_pos(input logic [2:0] cur, input logic [7:0] m, input logic d);
    last_pos = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!m[i] && (d ? (3'(i) < cur) : (3'(i) > cur))) last_pos = 1'b0;
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    oneshot_d   = oneshot_q;
    case (state_q)
      S_IDLE: begin
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start_ok && !stop) begin
          state_d     = S_RUN;
          sel_d       = first_pos(mask, dir);
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          dir_d       = dir;
          oneshot_d   = oneshot;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d     = S_IDLE;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (start_ok) begin
          sel_d       = first_pos(mask, dir);
          sel_valid_d = 1'b1;
          cnt_d       = '0;
          dir_d       = dir;
          oneshot_d   = oneshot;
        end else if (enable) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (mask == 8'hFF) begin
              state_d     = S_IDLE;
              sel_valid_d = 1'b0;
              busy_d      = 1'b0;
            end else if (oneshot_q && last_pos(sel_q, mask, dir_q)) begin
              state_d     = S_DONE;
              sel_valid_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              sel_d  = next_pos(sel_q, mask, dir_q);
              tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      oneshot_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      oneshot_q   <= oneshot_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: two instances (dwell 2 and dwell 1) share one stimulus stream,
// each checked every cycle against a position-list model, plus directed literal expectations.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic reset, start, stop, enable, dir, oneshot;
  logic [7:0] mask = 8'h00;
  logic [1:0][2:0] sel_o;
  logic [1:0] vld_o, tck_o, dn_o, bsy_o;
  logic chk_on = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable),
    .dir(dir), .oneshot(oneshot),
`ifdef SCAN_SEQUENCER_SKIP_MASK_EN
    .skip_mask(mask),
`endif
    .sel(sel_o[0]), .sel_valid(vld_o[0]), .tick(tck_o[0]), .done(dn_o[0]), .busy(bsy_o[0])
  );

  scan_sequencer #(.DWELL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable),
    .dir(dir), .oneshot(oneshot),
`ifdef SCAN_SEQUENCER_SKIP_MASK_EN
    .skip_mask(mask),
`endif
    .sel(sel_o[1]), .sel_valid(vld_o[1]), .tick(tck_o[1]), .done(dn_o[1]), .busy(bsy_o[1])
  );

  // Model: mode 0 idle, 1 sweeping, 2 completion cycle.
  int dw[2] = '{2, 1};
  int md[2], pos[2], cnt[2], ldir[2], los[2];
  bit mv[2], mt[2], mdn[2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_first(input logic [7:0] mk, input int d);
    for (int s = 0; s < 8; s++) begin
      int p;
      p = (d != 0) ? 7 - s : s;
      if (!mk[p]) return p;
    end
    return 0;
  endfunction

  function automatic int m_next(input int p0, input logic [7:0] mk, input int d);
    for (int s = 1; s <= 8; s++) begin
      int p;
      p = (((p0 + ((d != 0) ? -s : s)) % 8) + 8) % 8;
      if (!mk[p]) return p;
    end
    return p0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k] = 0; pos[k] = 0; cnt[k] = 0; ldir[k] = 0; los[k] = 0;
      mv[k] = 0; mt[k] = 0; mdn[k] = 0;
    end
  endtask

  task automatic model_step();
    bit st;
    int nx;
    st = start && (mask != 8'hFF);
    for (int k = 0; k < 2; k++) begin
      mt[k] = 0; mdn[k] = 0;
      if (stop) begin
        md[k] = 0; mv[k] = 0;
      end else if (md[k] != 2 && st) begin
        md[k] = 1; ldir[k] = int'(dir); los[k] = int'(oneshot);
        pos[k] = m_first(mask, int'(dir)); cnt[k] = 0; mv[k] = 1;
      end else if (md[k] == 2) begin
        md[k] = 0;
      end else if (md[k] == 1 && enable) begin
        if (cnt[k] + 1 == dw[k]) begin
          cnt[k] = 0;
          if (mask == 8'hFF) begin
            md[k] = 0; mv[k] = 0;
          end else begin
            nx = m_next(pos[k], mask, ldir[k]);
            // Completion when the next live position would require wrapping.
            if (los[k] != 0 && ((ldir[k] == 0) ? (nx <= pos[k]) : (nx >= pos[k]))) begin
              md[k] = 2; mv[k] = 0; mdn[k] = 1;
            end else begin
              pos[k] = nx; mt[k] = 1;
            end
          end
        end else begin
          cnt[k]++;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_sel", k), int'(sel_o[k]), pos[k]);
        chk($sformatf("m%0d_valid", k), int'(vld_o[k]), int'(mv[k]));
        chk($sformatf("m%0d_tick", k), int'(tck_o[k]), int'(mt[k]));
        chk($sformatf("m%0d_done", k), int'(dn_o[k]), int'(mdn[k]));
        chk($sformatf("m%0d_busy", k), int'(bsy_o[k]), int'(md[k] != 0));
      end
    end
  end

  int ntick;
  int n;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b1; dir = 1'b0; oneshot = 1'b0;
    model_reset();
    cyc(); cyc();
    chk_on = 1'b1;
    reset = 1'b0;
    cyc();
    chk("rst_sel", int'(sel_o[0]), 0);
    chk("rst_valid", int'(vld_o[0]), 0);
    chk("rst_busy", int'(bsy_o[0]), 0);

    // One-shot up sweep, dwell 2.
    dir = 1'b0; oneshot = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    ntick = 0;
    for (int k = 0; k < 16; k++) begin
      chk("A_sel", int'(sel_o[0]), k / 2);
      chk("A_valid", int'(vld_o[0]), 1);
      ntick += int'(tck_o[0]);
      cyc();
    end
    chk("A_ticks", ntick, 7);
    chk("A_done", int'(dn_o[0]), 1);
    chk("A_done_busy", int'(bsy_o[0]), 1);
    chk("A_done_valid", int'(vld_o[0]), 0);
    cyc();
    chk("A_idle_busy", int'(bsy_o[0]), 0);
    chk("A_idle_done", int'(dn_o[0]), 0);
    chk("A_idle_sel", int'(sel_o[0]), 7);

    // Continuous down sweep, dwell 1, wrap 0->7 ticks.
    dir = 1'b1; oneshot = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("B_sel", int'(sel_o[1]), (15 - k) % 8);
      chk("B_tick", int'(tck_o[1]), (k > 0) ? 1 : 0);
      chk("B_done", int'(dn_o[1]), 0);
      cyc();
    end
    stop = 1'b1; cyc(); stop = 1'b0;

    // Pause at sel=3 on the dwell-2 instance.
    dir = 1'b0; oneshot = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    chk("P_sel3", int'(sel_o[0]), 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("P_hold_sel", int'(sel_o[0]), 3);
      chk("P_hold_tick", int'(tck_o[0]), 0);
      chk("P_hold_valid", int'(vld_o[0]), 1);
    end
    enable = 1'b1;
    cyc();
    chk("P_rest_sel", int'(sel_o[0]), 3);
    cyc();
    chk("P_adv_sel", int'(sel_o[0]), 4);
    chk("P_adv_tick", int'(tck_o[0]), 1);

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("S_valid", int'(vld_o[0]), 0);
    chk("S_busy", int'(bsy_o[0]), 0);
    chk("S_done", int'(dn_o[0]), 0);
    dir = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    for (n = 0; n < 40 && sel_o[0] != 3'd4; n++) cyc();
    chk("S_reach4", int'(sel_o[0]), 4);
    start = 1'b1; cyc(); start = 1'b0;
    chk("R_sel", int'(sel_o[0]), 0);
    chk("R_tick", int'(tck_o[0]), 0);
    chk("R_valid", int'(vld_o[0]), 1);
    cyc();
    chk("R_sel_hold", int'(sel_o[0]), 0);
    cyc();
    chk("R_sel_next", int'(sel_o[0]), 1);

    // Asynchronous reset mid-sweep at sel=5.
    for (n = 0; n < 40 && sel_o[0] != 3'd5; n++) cyc();
    chk("X_reach5", int'(sel_o[0]), 5);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("X_sel", int'(sel_o[0]), 0);
    chk("X_valid", int'(vld_o[0]), 0);
    chk("X_busy", int'(bsy_o[0]), 0);
    chk("X_tick", int'(tck_o[0]), 0);
    chk("X_done", int'(dn_o[0]), 0);
    @(negedge clk);
    cyc();
    reset = 1'b0;
    cyc();
    chk("X_post_sel", int'(sel_o[0]), 0);
    chk("X_post_busy", int'(bsy_o[0]), 0);

`ifdef SCAN_SEQUENCER_SKIP_MASK_EN
    mask = 8'b1010_1010; dir = 1'b0; oneshot = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("K_sel", int'(sel_o[1]), 2 * k);
      cyc();
    end
    chk("K_done", int'(dn_o[1]), 1);
    cyc();
    mask = 8'hFF; start = 1'b1; cyc(); start = 1'b0;
    chk("K_ff_busy", int'(bsy_o[1]), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    mask = 8'h00;
`endif

    // Randomized traffic.
    repeat (3000) begin
      start   = ($urandom_range(9) == 0);
      stop    = ($urandom_range(29) == 0);
      enable  = ($urandom_range(3) != 0);
      dir     = 1'($urandom);
      oneshot = 1'($urandom);
`ifdef SCAN_SEQUENCER_SKIP_MASK_EN
      mask = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
`endif
      cyc();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
